// File: rtl/power_sequencer.sv
// rtl/power_sequencer.sv - timed five-phase power-up sequencer with cumulative rail enables
// Each phase loads its duration from the lookup table, counts prescaled ticks, then enables its rail.
module power_sequencer #(
  parameter int unsigned TICK_DIV = 20_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dur,
  output logic [2:0]  sel,
  output logic [4:0]  rail_en,
  output logic        phase_done,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    NEXT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] prescaler;
  logic [31:0]   remaining;
  logic [4:0]    rails;
  logic [4:0]    phase_bit;
  logic          tick;

  assign tick      = (prescaler == PRE_LAST);
  assign phase_bit = 5'd1 << (sel - 3'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = (dur == 32'd0) ? NEXT : RUN;
      RUN:  if (tick && remaining == 32'd1) state_nxt = NEXT;
      NEXT: state_nxt = (sel == 3'd5) ? DONE : LOAD;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    // Emergency shutdown overrides every other transition, including start in IDLE.
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      sel       <= 3'd1;
      rails     <= '0;
      prescaler <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: sel <= 3'd1;
        LOAD: begin
          remaining <= dur;
          prescaler <= '0;
        end
        RUN: begin
          if (tick) begin
            prescaler <= '0;
            if (remaining != 32'd1) remaining <= remaining - 32'd1;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        NEXT: begin
          rails <= rails | phase_bit;
          if (sel != 3'd5) sel <= sel + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // The current phase's rail is visible already during its NEXT cycle.
  assign rail_en    = (state == NEXT) ? (rails | phase_bit) : rails;
  assign phase_done = (state == NEXT);
  assign busy       = (state == LOAD) || (state == RUN) || (state == NEXT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_power_sequencer.sv
// tb/tb_power_sequencer.sv - self-checking bench for power_sequencer
// Two instances (TICK_DIV=4 and TICK_DIV=1) share control inputs; each has its own duration table.
module tb_power_sequencer;

  typedef int dur_arr_t [5];
  typedef struct {
    bit         inst_b;
    int         cyc;
    logic [4:0] rail;
    logic       pd;
    logic       dn;
  } cp_t;

  localparam int NONE = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [31:0] dur_a, dur_b;
  logic [2:0]  sel_a, sel_b;
  logic [4:0]  rail_a, rail_b;
  logic        pd_a, pd_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] tab_a [5];
  logic [31:0] tab_b [5];
  logic [10:0] trace_a [0:255];
  logic [10:0] trace_b [0:255];
  int          checks = 0;
  int          fails = 0;

  assign dur_a = (sel_a >= 3'd1 && sel_a <= 3'd5) ? tab_a[sel_a - 3'd1] : 32'hdead_beef;
  assign dur_b = (sel_b >= 3'd1 && sel_b <= 3'd5) ? tab_b[sel_b - 3'd1] : 32'hdead_beef;

  power_sequencer #(.TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dur(dur_a),
    .sel(sel_a), .rail_en(rail_a), .phase_done(pd_a), .busy(busy_a), .done(done_a)
  );

  power_sequencer #(.TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dur(dur_b),
    .sel(sel_b), .rail_en(rail_b), .phase_done(pd_b), .busy(busy_b), .done(done_b)
  );

  localparam logic [10:0] IDLE_OUT = {3'd1, 5'd0, 3'b000};

  // Expected {sel, rail_en, phase_done, busy, done} for cycle t after start, from the phase schedule.
  function automatic logic [10:0] model(int t, int td, dur_arr_t d, int kill_at);
    logic [4:0] rails;
    int load, nxt;
    rails = '0;
    load  = 1;
    if (t > kill_at || t <= 0) return IDLE_OUT;
    for (int k = 0; k < 5; k++) begin
      nxt = load + 1 + d[k] * td;
      if (t >= load && t <= nxt)
        return {3'(k + 1), (t == nxt) ? (rails | (5'd1 << k)) : rails, (t == nxt), 1'b1, 1'b0};
      rails = rails | (5'd1 << k);
      load  = nxt + 1;
    end
    return {3'd5, 5'h1f, 3'b001};
  endfunction

  function automatic int last_next(int td, dur_arr_t d);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) s += 2 + d[k] * td;
    return s;
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {sel,rail,pd,busy,done}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [10:0] obs_a();
    return {sel_a, rail_a, pd_a, busy_a, done_a};
  endfunction

  function automatic logic [10:0] obs_b();
    return {sel_b, rail_b, pd_b, busy_b, done_b};
  endfunction

  task automatic cleanup(input string tag);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check({tag, "_idle_a"}, obs_a(), IDLE_OUT);
    check({tag, "_idle_b"}, obs_b(), IDLE_OUT);
  endtask

  task automatic run_trial(input int ncyc, input int kill_at, input bit use_rst,
                           input bit hold_start, input string tag);
    dur_arr_t da, db;
    for (int k = 0; k < 5; k++) begin
      da[k] = int'(tab_a[k]);
      db[k] = int'(tab_b[k]);
    end
    start = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clk); #1;
      if (t == kill_at + 1) begin
        abort = 1'b0;
        rst   = 1'b0;
      end
      if (!hold_start || t > kill_at) start = 1'b0;
      trace_a[t] = obs_a();
      trace_b[t] = obs_b();
      check($sformatf("%s_a_c%0d", tag, t), trace_a[t], model(t, 4, da, kill_at));
      check($sformatf("%s_b_c%0d", tag, t), trace_b[t], model(t, 1, db, kill_at));
      if (t == kill_at) begin
        start = 1'b0;
        if (use_rst) rst = 1'b1;
        else         abort = 1'b1;
      end
    end
    cleanup(tag);
  endtask

  task automatic count_pulses(input string tag, input int ncyc);
    int ca, cb;
    ca = 0;
    cb = 0;
    for (int t = 1; t <= ncyc; t++) begin
      ca += int'(trace_a[t][2]);
      cb += int'(trace_b[t][2]);
    end
    check({tag, "_pulses_a"}, 11'(ca), 11'd5);
    check({tag, "_pulses_b"}, 11'(cb), 11'd5);
  endtask

  cp_t      cps [12];
  dur_arr_t rd_a, rd_b;

  initial begin
    logic [10:0] act;
    int          n, kill;
    bit          hold;

    cps[0]  = '{1'b0, 21, 5'b00000, 1'b0, 1'b0};
    cps[1]  = '{1'b0, 22, 5'b00001, 1'b1, 1'b0};
    cps[2]  = '{1'b0, 23, 5'b00001, 1'b0, 1'b0};
    cps[3]  = '{1'b0, 48, 5'b00011, 1'b1, 1'b0};
    cps[4]  = '{1'b0, 70, 5'b00111, 1'b1, 1'b0};
    cps[5]  = '{1'b0, 84, 5'b01111, 1'b1, 1'b0};
    cps[6]  = '{1'b0, 98, 5'b11111, 1'b1, 1'b0};
    cps[7]  = '{1'b0, 99, 5'b11111, 1'b0, 1'b1};
    cps[8]  = '{1'b0, 109, 5'b11111, 1'b0, 1'b1};
    cps[9]  = '{1'b1, 3, 5'b00001, 1'b1, 1'b0};
    cps[10] = '{1'b1, 15, 5'b11111, 1'b1, 1'b0};
    cps[11] = '{1'b1, 16, 5'b11111, 1'b0, 1'b1};

    tab_a = '{32'd5, 32'd6, 32'd5, 32'd3, 32'd3};
    tab_b = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", obs_a(), IDLE_OUT);
    check("reset_b", obs_b(), IDLE_OUT);

    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("rst_with_start_a", obs_a(), IDLE_OUT);
    check("rst_with_start_b", obs_b(), IDLE_OUT);
    @(posedge clk); #1;
    check("rst_with_start_hold_a", obs_a(), IDLE_OUT);

    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_with_start_a", obs_a(), IDLE_OUT);
    check("abort_with_start_b", obs_b(), IDLE_OUT);

    run_trial(110, NONE, 1'b0, 1'b0, "nominal");
    for (int i = 0; i < 12; i++) begin
      act = cps[i].inst_b ? trace_b[cps[i].cyc] : trace_a[cps[i].cyc];
      check($sformatf("checkpoint%0d", i), act & 11'b000_11111_101,
            {3'b000, cps[i].rail, cps[i].pd, 1'b0, cps[i].dn});
    end
    count_pulses("nominal", 110);

    run_trial(110, NONE, 1'b0, 1'b1, "held_start");
    count_pulses("held_start", 110);

    run_trial(40, 30, 1'b0, 1'b0, "abort_run");
    check("abort_run_c31", trace_a[31] & 11'b111_11111_010, 11'b001_00000_000);
    run_trial(110, NONE, 1'b0, 1'b0, "replay");
    count_pulses("replay", 110);

    run_trial(60, 55, 1'b1, 1'b0, "rst_mid");
    check("rst_mid_c56", trace_a[56], IDLE_OUT);

    tab_a = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    run_trial(30, NONE, 1'b0, 1'b0, "zero_dur");
    count_pulses("zero_dur", 30);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 5; k++) begin
        tab_a[k] = 32'($urandom_range(0, 5));
        tab_b[k] = 32'($urandom_range(0, 5));
        rd_a[k]  = int'(tab_a[k]);
        rd_b[k]  = int'(tab_b[k]);
      end
      n = last_next(4, rd_a);
      if (last_next(1, rd_b) > n) n = last_next(1, rd_b);
      n = n + 4;
      kill = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 2)) : NONE;
      hold = 1'($urandom_range(0, 1));
      run_trial(n, kill, 1'($urandom_range(0, 1)), hold, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
